// File: rtl/frame_sequencer_pkg.sv
// Shared state encoding and width helpers for the frame sequencer slice.
package frame_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_HBLANK = 3'd2;
  localparam logic [2:0] ST_LINE   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Counters that only ever hold 0..n-1 need at least one bit even for tiny n.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int row_w(input int height);
    return bits_for(height);
  endfunction

  function automatic int col_w(input int width);
    return bits_for(width);
  endfunction

  function automatic int addr_w(input int width, input int height);
    return bits_for(width * height);
  endfunction

  function automatic int cnt_w(input int start_delay, input int hsync_delay);
    return bits_for((start_delay > hsync_delay) ? start_delay : hsync_delay);
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Control/timing bundle between the frame sequencer and the pipeline stages it drives.
interface frame_sequencer_if
  import frame_seq_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) ();

  localparam int ROW_W  = row_w(HEIGHT);
  localparam int COL_W  = col_w(WIDTH);
  localparam int ADDR_W = addr_w(WIDTH, HEIGHT);

  logic              start;
  logic              stall;
  logic              VSYNC;
  logic              HSYNC;
  logic              pix_valid;
  logic [ADDR_W-1:0] addr;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              busy;
  logic              ctrl_done;

  modport master (
    input  start, stall,
    output VSYNC, HSYNC, pix_valid, addr, row, col, busy, ctrl_done
  );

  modport slave (
    output start, stall,
    input  VSYNC, HSYNC, pix_valid, addr, row, col, busy, ctrl_done
  );

endinterface

// File: rtl/frame_sequencer_delay_counter.sv
// Loadable down-counter that saturates at zero; times both the VSYNC and HBLANK phases.
module delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Sequences one frame: VSYNC lead-in, then per-line HBLANK + active LINE with raster address.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int START_DELAY = 100,
  parameter int HSYNC_DELAY = 160
) (
  input logic                HCLK,
  input logic                HRESETn,
  frame_sequencer_if.master  bus
);

  localparam int ROW_W  = row_w(HEIGHT);
  localparam int COL_W  = col_w(WIDTH);
  localparam int ADDR_W = addr_w(WIDTH, HEIGHT);
  localparam int CNT_W  = cnt_w(START_DELAY, HSYNC_DELAY);

  logic [2:0]        state, next_state;
  logic              cnt_load, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val, cnt_value;
  logic              advance, last_col, last_row;
  logic              vsync_q, hsync_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;

  delay_counter #(.W(CNT_W)) u_delay (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .load       (cnt_load),
    .load_value (cnt_load_val),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  assign advance  = (state == ST_LINE) && !bus.stall;
  assign last_col = (col_q == COL_W'(WIDTH - 1));
  assign last_row = (row_q == ROW_W'(HEIGHT - 1));

  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = CNT_W'(HSYNC_DELAY - 1);
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          next_state   = ST_VSYNC;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(START_DELAY - 1);
        end
      end
      ST_VSYNC: begin
        if (cnt_zero) begin
          next_state = ST_HBLANK;
          cnt_load   = 1'b1;
        end
      end
      ST_HBLANK: begin
        if (cnt_zero) next_state = ST_LINE;
      end
      ST_LINE: begin
        if (advance && last_col) begin
          if (last_row) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_HBLANK;
            cnt_load   = 1'b1;
          end
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Timing outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      vsync_q <= (next_state == ST_VSYNC);
      hsync_q <= (next_state == ST_LINE);
      busy_q  <= (next_state != ST_IDLE);
      done_q  <= (next_state == ST_DONE);
    end
  end

  // Address runs contiguously across line ends, so no row*WIDTH product is ever needed.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (next_state == ST_DONE) begin
      addr_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (advance) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  assign bus.VSYNC     = vsync_q;
  assign bus.HSYNC     = hsync_q;
  assign bus.busy      = busy_q;
  assign bus.ctrl_done = done_q;
  assign bus.addr      = addr_q;
  assign bus.row       = row_q;
  assign bus.col       = col_q;
  assign bus.pix_valid = (state == ST_LINE) && !bus.stall;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Controller that sequences one frame of the image preprocessing pipeline. On a start pulse it generates VSYNC and per-line HSYNC timing with programmable blanking. It also produces the raster pixel address, row and column, and a pixel-valid strobe that the image reader, remover and writer stages consume. It honours a downstream stall and signals frame completion on ctrl_done.

Parameters:
WIDTH, 768, pixels per line (>=2)
HEIGHT, 512, lines per frame (>=2)
START_DELAY, 100, cycles VSYNC is held high before the first line (>=1)
HSYNC_DELAY, 160, blanking cycles before each line, HSYNC low (>=1)
ADDR_W, clog2(WIDTH*HEIGHT), pixel address width (derived; do not override)

Ports:
HCLK  in  1  clock, rising edge
HRESETn  in  1  asynchronous active-low reset
start  in  1  frame start request, sampled only in IDLE
stall  in  1  downstream not ready; freezes pixel advance in LINE only
VSYNC  out  1  high during start delay
HSYNC  out  1  high while a line is active, including stalled cycles
pix_valid  out  1  pixel address valid this cycle (LINE && !stall)
addr  out  ADDR_W  row*WIDTH+col of the current pixel
row  out  clog2(HEIGHT)  current line index
col  out  clog2(WIDTH)  current pixel index within the line
busy  out  1  high in every state except IDLE
ctrl_done  out  1  one-cycle pulse after the last pixel of the frame

Behaviour:
- Reset (async, any state): state=IDLE; VSYNC, HSYNC, busy and ctrl_done = 0; addr, row, col and the delay counter = 0. Reset mid-frame aborts the frame. No ctrl_done is issued for an aborted frame.
- All outputs are registered, except pix_valid = (state==LINE) && !stall, which is combinational.
- States: IDLE -> VSYNC -> HBLANK -> LINE -> (HBLANK | DONE) -> IDLE.
- IDLE: if start is high at an edge, go to VSYNC and load counter = START_DELAY-1. A start outside IDLE is ignored (no queuing).
- VSYNC: VSYNC=1 for exactly START_DELAY cycles. When the counter reaches 0, go to HBLANK and load counter = HSYNC_DELAY-1.
- HBLANK: VSYNC=0, HSYNC=0 for exactly HSYNC_DELAY cycles, then go to LINE.
- LINE: HSYNC=1.
  - On each cycle with !stall: col increments and addr increments by 1.
  - On a stalled cycle: row, col and addr all hold.
  - At col==WIDTH-1 with !stall:
    - if row==HEIGHT-1, go to DONE;
    - otherwise row increments, col=0, addr increments (contiguous), and the next state is HBLANK with the counter reloaded.
- DONE: ctrl_done=1 for one cycle, HSYNC=0, busy=1; row, col and addr clear to 0. Next state is IDLE. A start arriving during DONE is ignored.
- stall in IDLE, VSYNC, HBLANK and DONE has no effect; the delay counters never stall.
- Unstalled frame length: START_DELAY + HEIGHT*(HSYNC_DELAY+WIDTH) cycles from the first VSYNC cycle, with ctrl_done in the next cycle.
- Address arithmetic: addr is kept incrementally (no multiplier). Its maximum value is WIDTH*HEIGHT-1, and it never wraps within a frame.

Decomposition:
- Package frame_seq_pkg holds:
  - the state enum (IDLE, VSYNC, HBLANK, LINE, DONE);
  - width functions/constants for row, col and addr derived from WIDTH and HEIGHT.
- One sub-module: delay_counter. It is a loadable down-counter with load, value and zero flag, shared by the VSYNC and HBLANK phases.

Test Plan:
- WIDTH=4, HEIGHT=3, START_DELAY=5, HSYNC_DELAY=2, start pulse, no stall -> VSYNC high for cycles 0-4; HSYNC high for 4-cycle windows starting at cycles 7, 13 and 19; addr 0..11 in order; ctrl_done at cycle 23; busy low at cycle 24.
- Same parameters, stall high for 3 cycles at addr=5 -> addr, row and col hold at 5/1/1 with HSYNC=1 and pix_valid=0; ctrl_done moves to cycle 26.
- Stall held high throughout VSYNC and HBLANK -> no effect on timing; pixel advance begins once stall drops in LINE.
- start re-pulsed during LINE and during DONE -> ignored; exactly one ctrl_done is seen, and the next frame starts only after a start while in IDLE.
- HRESETn asserted at addr=7 -> all outputs 0 immediately (async); no ctrl_done; a fresh start after release yields the full cycle-23 profile again.
- Back-to-back frames (start asserted in the first IDLE cycle after DONE) -> the second frame's VSYNC begins one cycle after the IDLE cycle; addr restarts at 0.
